// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-bus memory controller: FSM states, access
// size codes, the data word type and the default IO window base.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  typedef logic [31:0] data_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam data_t ZERO_WORD       = 32'h0000_0000;
  localparam logic  TRUE            = 1'b1;
  localparam logic  FALSE           = 1'b0;
  localparam data_t IO_BASE_DEFAULT = 32'h0003_0000;

  // Any code other than byte or half is treated as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller, the byte-wide RAM/IO port,
// the instruction fetcher, the LSB and the ROB flush line.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic [7:0] in_mem_din;
  logic [7:0] out_mem_dout;
  data_t      out_mem_a;
  logic       out_mem_wr;
  logic       in_io_buffer_full;

  logic       in_fetcher_flag;
  data_t      in_fetcher_pc;
  logic       out_fetcher_flag;
  data_t      out_fetcher_inst;

  logic       in_lsb_flag;
  logic       in_lsb_store;
  data_t      in_lsb_addr;
  logic [1:0] in_lsb_size;
  data_t      in_lsb_data;
  logic       out_lsb_flag;
  data_t      out_lsb_data;

  logic       in_rob_xbp;

  // Controller side
  modport slave (
    input  in_mem_din, in_io_buffer_full,
    input  in_fetcher_flag, in_fetcher_pc,
    input  in_lsb_flag, in_lsb_store, in_lsb_addr, in_lsb_size, in_lsb_data,
    input  in_rob_xbp,
    output out_mem_dout, out_mem_a, out_mem_wr,
    output out_fetcher_flag, out_fetcher_inst,
    output out_lsb_flag, out_lsb_data
  );

  // Environment side (RAM/IO, fetcher, LSB, ROB)
  modport master (
    output in_mem_din, in_io_buffer_full,
    output in_fetcher_flag, in_fetcher_pc,
    output in_lsb_flag, in_lsb_store, in_lsb_addr, in_lsb_size, in_lsb_data,
    output in_rob_xbp,
    input  out_mem_dout, out_mem_a, out_mem_wr,
    input  out_fetcher_flag, out_fetcher_inst,
    input  out_lsb_flag, out_lsb_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port byte-bus memory controller arbitrating fetches and LSB accesses.
// Optional MEM_CTRL_IO_STALL_EN: IO-region store bytes wait while the IO buffer is full.
//
// state    | meaning
// IDLE     | bus idle; arbitrate pending slots (LSB beats fetch)
// FETCH    | reading 4 instruction bytes, stage k = k_q
// LOAD     | reading 1/2/4 data bytes, stage k = k_q
// STORE    | writing 1/2/4 data bytes, stage k = k_q
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter data_t IO_BASE = IO_BASE_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [2:0] n_q, n_d;
  data_t      addr_q, addr_d;
  data_t      wdata_q, wdata_d;
  data_t      buf_q, buf_d;
  data_t      inst_q, inst_d;
  data_t      ldata_q, ldata_d;

  logic       pend_f_q, pend_f_d;
  data_t      pend_pc_q, pend_pc_d;
  logic       pend_l_q, pend_l_d;
  logic       pend_st_q, pend_st_d;
  data_t      pend_la_q, pend_la_d;
  logic [1:0] pend_sz_q, pend_sz_d;
  data_t      pend_ld_q, pend_ld_d;

  logic       pend_f_v, pend_l_v, pend_st_v;
  data_t      pend_pc_v, pend_la_v, pend_ld_v;
  logic [1:0] pend_sz_v;

  data_t      cur_addr;
  data_t      cap_w;
  logic [1:0] cap_idx;
  logic [7:0] wbyte;
  logic       io_stall;
  logic       f_done, l_done, mem_wr;
  data_t      mem_a;
  logic [7:0] mem_dout;

  assign cur_addr = addr_q + {29'd0, k_q};
  assign cap_idx  = k_q[1:0] - 2'd1;
  assign wbyte    = wdata_q[{k_q[1:0], 3'b000} +: 8];

  always_comb begin
    cap_w = buf_q;
    cap_w[{cap_idx, 3'b000} +: 8] = bus.in_mem_din;
  end

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_stall = (state_q == ST_STORE) && bus.in_io_buffer_full && (cur_addr >= IO_BASE);
`else
  logic io_full_unused;
  assign io_full_unused = bus.in_io_buffer_full;
  assign io_stall       = FALSE;
`endif

  // Effective pending slots: a flush drops speculative traffic, stores survive.
  always_comb begin
    pend_f_v  = (pend_f_q && !bus.in_rob_xbp) || (bus.in_fetcher_flag && !bus.in_rob_xbp);
    pend_pc_v = bus.in_fetcher_flag ? bus.in_fetcher_pc : pend_pc_q;
    if (bus.in_lsb_flag && (bus.in_lsb_store || !bus.in_rob_xbp)) begin
      pend_l_v  = TRUE;
      pend_st_v = bus.in_lsb_store;
      pend_la_v = bus.in_lsb_addr;
      pend_sz_v = bus.in_lsb_size;
      pend_ld_v = bus.in_lsb_data;
    end else begin
      pend_l_v  = pend_l_q && (pend_st_q || !bus.in_rob_xbp);
      pend_st_v = pend_st_q;
      pend_la_v = pend_la_q;
      pend_sz_v = pend_sz_q;
      pend_ld_v = pend_ld_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    inst_d    = inst_q;
    ldata_d   = ldata_q;
    pend_f_d  = pend_f_v;
    pend_pc_d = pend_pc_v;
    pend_l_d  = pend_l_v;
    pend_st_d = pend_st_v;
    pend_la_d = pend_la_v;
    pend_sz_d = pend_sz_v;
    pend_ld_d = pend_ld_v;
    mem_a     = ZERO_WORD;
    mem_wr    = FALSE;
    mem_dout  = 8'h00;
    f_done    = FALSE;
    l_done    = FALSE;

    case (state_q)
      ST_IDLE: begin
        k_d   = 3'd0;
        buf_d = ZERO_WORD;
        if (pend_l_v) begin
          state_d  = pend_st_v ? ST_STORE : ST_LOAD;
          addr_d   = pend_la_v;
          n_d      = size_bytes(pend_sz_v);
          wdata_d  = pend_ld_v;
          pend_l_d = FALSE;
        end else if (pend_f_v) begin
          state_d  = ST_FETCH;
          addr_d   = pend_pc_v;
          n_d      = 3'd4;
          pend_f_d = FALSE;
        end
      end

      ST_FETCH, ST_LOAD: begin
        if (k_q < n_q) mem_a = cur_addr;
        if (bus.in_rob_xbp) begin
          state_d = ST_IDLE;
        end else begin
          if (k_q != 3'd0) buf_d = cap_w;
          if (k_q == n_q) begin
            state_d = ST_IDLE;
            if (state_q == ST_FETCH) begin
              inst_d = cap_w;
              f_done = TRUE;
            end else begin
              ldata_d = cap_w;
              l_done  = TRUE;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      ST_STORE: begin
        if (k_q < n_q) begin
          mem_a = cur_addr;
          if (!io_stall) begin
            mem_wr   = TRUE;
            mem_dout = wbyte;
            k_d      = k_q + 3'd1;
          end
        end else begin
          l_done  = TRUE;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.out_mem_a        = mem_a;
  assign bus.out_mem_dout     = mem_dout;
  assign bus.out_mem_wr       = mem_wr && rdy;
  assign bus.out_fetcher_flag = f_done && rdy;
  assign bus.out_fetcher_inst = bus.out_fetcher_flag ? inst_d : inst_q;
  assign bus.out_lsb_flag     = l_done && rdy;
  assign bus.out_lsb_data     = bus.out_lsb_flag ? ldata_d : ldata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= 3'd0;
      n_q       <= 3'd0;
      addr_q    <= ZERO_WORD;
      wdata_q   <= ZERO_WORD;
      buf_q     <= ZERO_WORD;
      inst_q    <= ZERO_WORD;
      ldata_q   <= ZERO_WORD;
      pend_f_q  <= FALSE;
      pend_pc_q <= ZERO_WORD;
      pend_l_q  <= FALSE;
      pend_st_q <= FALSE;
      pend_la_q <= ZERO_WORD;
      pend_sz_q <= SIZE_B;
      pend_ld_q <= ZERO_WORD;
    end else if (rdy) begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      inst_q    <= inst_d;
      ldata_q   <= ldata_d;
      pend_f_q  <= pend_f_d;
      pend_pc_q <= pend_pc_d;
      pend_l_q  <= pend_l_d;
      pend_st_q <= pend_st_d;
      pend_la_q <= pend_la_d;
      pend_sz_q <= pend_sz_d;
      pend_ld_q <= pend_ld_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a registered-read byte RAM model.
// Follows MEM_CTRL_IO_STALL_EN the same way as the design.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [7:0] ram [4096];
  int         wr_cnt = 0;
  logic [31:0] last_a;
  logic [7:0]  last_d;

  mem_ctrl_if bus();

  mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM returns the byte one cycle after the address; writes are only logged.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.out_mem_wr) begin
        wr_cnt <= wr_cnt + 1;
        last_a <= bus.out_mem_a;
        last_d <= bus.out_mem_dout;
      end
      bus.in_mem_din <= (bus.out_mem_a < 32'd4096) ? ram[bus.out_mem_a[11:0]] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_fetcher_flag   = 1'b0;
    bus.in_fetcher_pc     = 32'h0;
    bus.in_lsb_flag       = 1'b0;
    bus.in_lsb_store      = 1'b0;
    bus.in_lsb_addr       = 32'h0;
    bus.in_lsb_size       = 2'd0;
    bus.in_lsb_data       = 32'h0;
    bus.in_rob_xbp        = 1'b0;
    bus.in_io_buffer_full = 1'b0;
  endtask

  task automatic lsb_pulse(input logic st, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d);
    bus.in_lsb_flag  = 1'b1;
    bus.in_lsb_store = st;
    bus.in_lsb_addr  = a;
    bus.in_lsb_size  = sz;
    bus.in_lsb_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    tick(); tick(); tick();
    n_chk++;
    if (bus.out_fetcher_flag !== 1'b0 || bus.out_lsb_flag !== 1'b0 || bus.out_mem_wr !== 1'b0)
      $display("FAIL reset_flags got f=%b l=%b wr=%b exp 0 0 0",
               bus.out_fetcher_flag, bus.out_lsb_flag, bus.out_mem_wr);
    else n_pass++;
    n_chk++;
    if (bus.out_mem_a !== 32'h0 || bus.out_mem_dout !== 8'h00)
      $display("FAIL reset_bus got a=%h dout=%h exp 0 0", bus.out_mem_a, bus.out_mem_dout);
    else n_pass++;
    n_chk++;
    if (bus.out_fetcher_inst !== 32'h0 || bus.out_lsb_data !== 32'h0)
      $display("FAIL reset_data got inst=%h ld=%h exp 0 0", bus.out_fetcher_inst, bus.out_lsb_data);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    bus.in_fetcher_pc   = 32'h0;
    bus.in_fetcher_flag = 1'b1;
    tick();
    bus.in_fetcher_flag = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        n_chk++;
        if (bus.out_mem_a !== 32'(c - 1) || bus.out_mem_wr !== 1'b0 || bus.out_fetcher_flag !== 1'b0)
          $display("FAIL fetch_issue c=%0d got a=%h wr=%b f=%b exp a=%h wr=0 f=0",
                   c, bus.out_mem_a, bus.out_mem_wr, bus.out_fetcher_flag, 32'(c - 1));
        else n_pass++;
      end else if (c == 5) begin
        n_chk++;
        if (bus.out_fetcher_flag !== 1'b1 || bus.out_fetcher_inst !== 32'h0000_0513)
          $display("FAIL fetch_done got f=%b inst=%h exp 1 00000513",
                   bus.out_fetcher_flag, bus.out_fetcher_inst);
        else n_pass++;
        n_chk++;
        if (bus.out_mem_a !== 32'h0)
          $display("FAIL fetch_no_fifth_read got a=%h exp 0", bus.out_mem_a);
        else n_pass++;
      end else begin
        n_chk++;
        if (bus.out_fetcher_flag !== 1'b0 || bus.out_fetcher_inst !== 32'h0000_0513)
          $display("FAIL fetch_hold got f=%b inst=%h exp 0 00000513",
                   bus.out_fetcher_flag, bus.out_fetcher_inst);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_load_half();
    lsb_pulse(1'b0, 32'h101, SIZE_H, 32'h0);
    tick();
    bus.in_lsb_flag = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c <= 2) begin
        n_chk++;
        if (bus.out_mem_a !== 32'h100 + 32'(c) || bus.out_lsb_flag !== 1'b0)
          $display("FAIL ldh_issue c=%0d got a=%h l=%b exp a=%h l=0",
                   c, bus.out_mem_a, bus.out_lsb_flag, 32'h100 + 32'(c));
        else n_pass++;
      end else begin
        n_chk++;
        if (bus.out_lsb_flag !== (c == 3) || bus.out_lsb_data !== 32'h0000_1234)
          $display("FAIL ldh_done c=%0d got l=%b d=%h exp l=%b d=00001234",
                   c, bus.out_lsb_flag, bus.out_lsb_data, (c == 3));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_store_word();
    logic [7:0] exp_b [4];
    int         cnt0;
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    cnt0  = wr_cnt;
    lsb_pulse(1'b1, 32'h200, SIZE_W, 32'hDEAD_BEEF);
    tick();
    bus.in_lsb_flag = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) begin
        n_chk++;
        if (bus.out_mem_wr !== 1'b1 || bus.out_mem_a !== 32'h1FF + 32'(c) ||
            bus.out_mem_dout !== exp_b[c - 1] || bus.out_lsb_flag !== 1'b0)
          $display("FAIL stw_byte c=%0d got wr=%b a=%h d=%h l=%b exp wr=1 a=%h d=%h l=0",
                   c, bus.out_mem_wr, bus.out_mem_a, bus.out_mem_dout, bus.out_lsb_flag,
                   32'h1FF + 32'(c), exp_b[c - 1]);
        else n_pass++;
      end else begin
        n_chk++;
        if (bus.out_mem_wr !== 1'b0 || bus.out_lsb_flag !== 1'b1)
          $display("FAIL stw_done got wr=%b l=%b exp 0 1", bus.out_mem_wr, bus.out_lsb_flag);
        else n_pass++;
      end
      tick();
    end
    n_chk++;
    if (wr_cnt - cnt0 !== 4 || last_a !== 32'h203 || last_d !== 8'hDE)
      $display("FAIL stw_count got n=%0d last=%h/%h exp 4 00000203/de", wr_cnt - cnt0, last_a, last_d);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int    f_cyc = -1;
    int    l_cyc = -1;
    data_t f_dat = '0;
    data_t l_dat = '0;
    bus.in_fetcher_pc   = 32'h10;
    bus.in_fetcher_flag = 1'b1;
    lsb_pulse(1'b0, 32'h20, SIZE_W, 32'h0);
    tick();
    bus.in_fetcher_flag = 1'b0;
    bus.in_lsb_flag     = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (bus.out_fetcher_flag === 1'b1) begin f_cyc = c; f_dat = bus.out_fetcher_inst; end
      if (bus.out_lsb_flag === 1'b1)     begin l_cyc = c; l_dat = bus.out_lsb_data; end
      if (c == 6) begin
        n_chk++;
        if (bus.out_mem_a !== 32'h0) $display("FAIL arb_gap got a=%h exp 0", bus.out_mem_a);
        else n_pass++;
      end
      if (c == 7) begin
        n_chk++;
        if (bus.out_mem_a !== 32'h10) $display("FAIL arb_fetch_start got a=%h exp 10", bus.out_mem_a);
        else n_pass++;
      end
      tick();
    end
    n_chk++;
    if (l_cyc != 5 || l_dat !== 32'h1234_5678)
      $display("FAIL arb_load got cyc=%0d d=%h exp 5 12345678", l_cyc, l_dat);
    else n_pass++;
    n_chk++;
    if (f_cyc != 11 || f_dat !== 32'h0010_0093)
      $display("FAIL arb_fetch got cyc=%0d d=%h exp 11 00100093", f_cyc, f_dat);
    else n_pass++;
  endtask

  task automatic test_xbp();
    int seen;
    int l_cyc;
    // flush during fetch stage 2
    bus.in_fetcher_pc   = 32'h0;
    bus.in_fetcher_flag = 1'b1;
    tick();
    bus.in_fetcher_flag = 1'b0;
    tick(); tick();
    bus.in_rob_xbp = 1'b1;
    #1;
    n_chk++;
    if (bus.out_mem_a !== 32'h2) $display("FAIL xbp_stage2 got a=%h exp 2", bus.out_mem_a);
    else n_pass++;
    tick();
    bus.in_rob_xbp = 1'b0;
    #1;
    n_chk++;
    if (bus.out_mem_a !== 32'h0 || bus.out_mem_wr !== 1'b0)
      $display("FAIL xbp_idle got a=%h wr=%b exp 0 0", bus.out_mem_a, bus.out_mem_wr);
    else n_pass++;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_fetcher_flag === 1'b1) seen++;
      tick();
    end
    n_chk++;
    if (seen != 0 || bus.out_fetcher_inst !== 32'h0010_0093)
      $display("FAIL xbp_fetch_abort got pulses=%0d inst=%h exp 0 00100093", seen, bus.out_fetcher_inst);
    else n_pass++;

    // store pulse with flush held high throughout still completes
    lsb_pulse(1'b1, 32'h300, SIZE_H, 32'h0000_A55A);
    bus.in_rob_xbp = 1'b1;
    tick();
    bus.in_lsb_flag = 1'b0;
    n_chk++;
    if (bus.out_mem_wr !== 1'b1 || bus.out_mem_a !== 32'h300 || bus.out_mem_dout !== 8'h5A)
      $display("FAIL xbp_st_b0 got wr=%b a=%h d=%h exp 1 300 5a", bus.out_mem_wr, bus.out_mem_a, bus.out_mem_dout);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.out_mem_wr !== 1'b1 || bus.out_mem_a !== 32'h301 || bus.out_mem_dout !== 8'hA5)
      $display("FAIL xbp_st_b1 got wr=%b a=%h d=%h exp 1 301 a5", bus.out_mem_wr, bus.out_mem_a, bus.out_mem_dout);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.out_lsb_flag !== 1'b1 || bus.out_mem_wr !== 1'b0)
      $display("FAIL xbp_st_done got l=%b wr=%b exp 1 0", bus.out_lsb_flag, bus.out_mem_wr);
    else n_pass++;
    tick();

    // load pulse coinciding with flush is dropped
    lsb_pulse(1'b0, 32'h101, SIZE_B, 32'h0);
    tick();
    bus.in_lsb_flag = 1'b0;
    bus.in_rob_xbp  = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.out_lsb_flag === 1'b1 || bus.out_mem_a !== 32'h0) seen++;
      tick();
    end
    n_chk++;
    if (seen != 0) $display("FAIL xbp_load_drop got busy_cycles=%0d exp 0", seen);
    else n_pass++;

    // flush in the done cycle of a load suppresses the pulse
    lsb_pulse(1'b0, 32'h102, SIZE_B, 32'h0);
    tick();
    bus.in_lsb_flag = 1'b0;
    n_chk++;
    if (bus.out_mem_a !== 32'h102) $display("FAIL xbp_ld_issue got a=%h exp 102", bus.out_mem_a);
    else n_pass++;
    tick();
    bus.in_rob_xbp = 1'b1;
    #1;
    n_chk++;
    if (bus.out_lsb_flag !== 1'b0 || bus.out_lsb_data !== 32'h1234_5678)
      $display("FAIL xbp_ld_done got l=%b d=%h exp 0 12345678", bus.out_lsb_flag, bus.out_lsb_data);
    else n_pass++;
    tick();
    bus.in_rob_xbp = 1'b0;
    #1;
    n_chk++;
    if (bus.out_lsb_flag !== 1'b0 || bus.out_mem_a !== 32'h0)
      $display("FAIL xbp_ld_after got l=%b a=%h exp 0 0", bus.out_lsb_flag, bus.out_mem_a);
    else n_pass++;

    // pending fetch queued behind a store is cleared by a flush
    lsb_pulse(1'b1, 32'h210, SIZE_W, 32'h0102_0304);
    tick();
    bus.in_lsb_flag     = 1'b0;
    bus.in_fetcher_pc   = 32'h10;
    bus.in_fetcher_flag = 1'b1;
    tick();
    bus.in_fetcher_flag = 1'b0;
    bus.in_rob_xbp      = 1'b1;
    tick();
    bus.in_rob_xbp = 1'b0;
    seen  = 0;
    l_cyc = -1;
    for (int c = 3; c <= 14; c++) begin
      if (bus.out_fetcher_flag === 1'b1) seen++;
      if (bus.out_lsb_flag === 1'b1) l_cyc = c;
      tick();
    end
    n_chk++;
    if (seen != 0 || l_cyc != 5)
      $display("FAIL xbp_pend_fetch got fetch_pulses=%0d store_done=%0d exp 0 5", seen, l_cyc);
    else n_pass++;
  endtask

  task automatic test_rdy();
    lsb_pulse(1'b1, 32'h310, SIZE_B, 32'h0000_0077);
    tick();
    bus.in_lsb_flag = 1'b0;
    rdy = 1'b0;
    #1;
    for (int c = 1; c <= 3; c++) begin
      n_chk++;
      if (bus.out_mem_wr !== 1'b0 || bus.out_mem_a !== 32'h310 || bus.out_lsb_flag !== 1'b0)
        $display("FAIL rdy_hold c=%0d got wr=%b a=%h l=%b exp 0 310 0",
                 c, bus.out_mem_wr, bus.out_mem_a, bus.out_lsb_flag);
      else n_pass++;
      tick();
    end
    rdy = 1'b1;
    #1;
    n_chk++;
    if (bus.out_mem_wr !== 1'b1 || bus.out_mem_a !== 32'h310 || bus.out_mem_dout !== 8'h77)
      $display("FAIL rdy_resume got wr=%b a=%h d=%h exp 1 310 77", bus.out_mem_wr, bus.out_mem_a, bus.out_mem_dout);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.out_lsb_flag !== 1'b1) $display("FAIL rdy_done got l=%b exp 1", bus.out_lsb_flag);
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    lsb_pulse(1'b0, 32'hFFFF_FFFF, SIZE_H, 32'h0);
    tick();
    bus.in_lsb_flag = 1'b0;
    n_chk++;
    if (bus.out_mem_a !== 32'hFFFF_FFFF) $display("FAIL wrap_a0 got a=%h exp ffffffff", bus.out_mem_a);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.out_mem_a !== 32'h0 || bus.out_lsb_flag !== 1'b0)
      $display("FAIL wrap_a1 got a=%h l=%b exp 0 0", bus.out_mem_a, bus.out_lsb_flag);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.out_lsb_flag !== 1'b1 || bus.out_lsb_data !== 32'h0000_1300)
      $display("FAIL wrap_done got l=%b d=%h exp 1 00001300", bus.out_lsb_flag, bus.out_lsb_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_io_stall();
    int cnt0;
    cnt0 = wr_cnt;
    bus.in_io_buffer_full = 1'b1;
    lsb_pulse(1'b1, 32'h0003_0004, SIZE_B, 32'h0000_005C);
    tick();
    bus.in_lsb_flag = 1'b0;
`ifdef MEM_CTRL_IO_STALL_EN
    for (int c = 1; c <= 3; c++) begin
      n_chk++;
      if (bus.out_mem_wr !== 1'b0 || bus.out_lsb_flag !== 1'b0)
        $display("FAIL io_stall c=%0d got wr=%b l=%b exp 0 0", c, bus.out_mem_wr, bus.out_lsb_flag);
      else n_pass++;
      tick();
    end
    bus.in_io_buffer_full = 1'b0;
    #1;
`endif
    n_chk++;
    if (bus.out_mem_wr !== 1'b1 || bus.out_mem_a !== 32'h0003_0004 || bus.out_mem_dout !== 8'h5C)
      $display("FAIL io_write got wr=%b a=%h d=%h exp 1 00030004 5c", bus.out_mem_wr, bus.out_mem_a, bus.out_mem_dout);
    else n_pass++;
    tick();
    bus.in_io_buffer_full = 1'b0;
    n_chk++;
    if (bus.out_lsb_flag !== 1'b1 || bus.out_mem_wr !== 1'b0)
      $display("FAIL io_done got l=%b wr=%b exp 1 0", bus.out_lsb_flag, bus.out_mem_wr);
    else n_pass++;
    tick();
    n_chk++;
    if (wr_cnt - cnt0 !== 1) $display("FAIL io_count got n=%0d exp 1", wr_cnt - cnt0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int busy;
    bus.in_fetcher_pc   = 32'h10;
    bus.in_fetcher_flag = 1'b1;
    lsb_pulse(1'b0, 32'h20, SIZE_W, 32'h0);
    tick();
    bus.in_fetcher_flag = 1'b0;
    bus.in_lsb_flag     = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_fetcher_flag === 1'b1 || bus.out_lsb_flag === 1'b1 ||
          bus.out_mem_a !== 32'h0 || bus.out_mem_wr !== 1'b0) busy++;
      tick();
    end
    n_chk++;
    if (busy != 0) $display("FAIL reset_mid_quiet got busy_cycles=%0d exp 0", busy);
    else n_pass++;
    n_chk++;
    if (bus.out_fetcher_inst !== 32'h0 || bus.out_lsb_data !== 32'h0)
      $display("FAIL reset_mid_data got inst=%h ld=%h exp 0 0", bus.out_fetcher_inst, bus.out_lsb_data);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h000] = 8'h13; ram[12'h001] = 8'h05; ram[12'h002] = 8'h00; ram[12'h003] = 8'h00;
    ram[12'h010] = 8'h93; ram[12'h011] = 8'h00; ram[12'h012] = 8'h10; ram[12'h013] = 8'h00;
    ram[12'h020] = 8'h78; ram[12'h021] = 8'h56; ram[12'h022] = 8'h34; ram[12'h023] = 8'h12;
    ram[12'h101] = 8'h34; ram[12'h102] = 8'h12; ram[12'h103] = 8'hAA;

    test_reset();
    test_fetch();
    test_load_half();
    test_store_word();
    test_arbitration();
    test_xbp();
    test_rdy();
    test_wrap();
    test_io_stall();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller upstream of the fetcher and the LSB.
- Arbitrates instruction fetches and LSB loads/stores onto the byte-wide RAM/IO bus.
- Assembles multi-byte words (little-endian) and returns them with a one-cycle done pulse.
- Honours ROB misprediction flush for speculative traffic only.

Parameters:
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO-mapped.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state holds while low
- in_mem_din  in  8  RAM/IO read byte, valid one cycle after address issue
- out_mem_dout  out  8  write byte
- out_mem_a  out  32  byte address
- out_mem_wr  out  1  1 = write
- in_io_buffer_full  in  1  IO write buffer full
- in_fetcher_flag  in  1  one-cycle fetch request pulse
- in_fetcher_pc  in  32  fetch address (word aligned)
- out_fetcher_flag  out  1  one-cycle pulse, instruction valid
- out_fetcher_inst  out  32  fetched instruction
- in_lsb_flag  in  1  one-cycle LSB request pulse
- in_lsb_store  in  1  1 = store, 0 = load
- in_lsb_addr  in  32  byte address
- in_lsb_size  in  2  0 = byte, 1 = half, 2 = word
- in_lsb_data  in  32  store data (low bytes used)
- out_lsb_flag  out  1  one-cycle done pulse (load data valid / store complete)
- out_lsb_data  out  32  load data, zero-extended
- in_rob_xbp  in  1  misprediction flush

Behaviour:
- Reset:
  - All outputs 0; state IDLE; pending slots cleared.
  - Reset mid-transaction abandons it silently.
- rdy low: no state or register change; out_mem_wr forced 0.
- Request latching:
  - Each request pulse latches into its own pending slot (fetch, LSB), including while the controller is busy.
  - A second pulse on an occupied slot is a protocol violation; behaviour is unspecified.
- Arbitration in IDLE:
  - LSB pending beats fetch pending.
  - The chosen slot moves to the active transaction the same cycle.
  - Stage counter k is cleared.
- States: IDLE, FETCH, LOAD, STORE.
- Byte count n: FETCH = 4; LOAD/STORE = 1/2/4 by size.
- FETCH/LOAD:
  - At stage k < n, drive out_mem_a = addr + k with out_mem_wr = 0.
  - At stage k >= 1, capture in_mem_din into byte k-1.
  - At stage k == n, capture the last byte, pulse the done flag and data, and return to IDLE.
  - Request-latch to done pulse: n+1 cycles.
  - Unused upper load bytes are 0.
- STORE:
  - At stage k < n, drive out_mem_a = addr + k, out_mem_wr = 1, out_mem_dout = data byte k.
  - The cycle after the last byte: out_mem_wr = 0, pulse out_lsb_flag, go to IDLE.
  - Latency: n+1 cycles.
- Idle bus: out_mem_wr = 0, out_mem_a = 0.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- in_rob_xbp:
  - Clears the pending fetch slot.
  - Aborts an active FETCH or LOAD to IDLE next cycle, with no done pulse.
  - Clears a pending LSB load.
  - An active or pending STORE is never cancelled (stores are committed).
  - xbp coinciding with a done cycle suppresses that done pulse for FETCH/LOAD.
  - xbp coinciding with a new request pulse: the pulse is dropped, except store pulses.
- Done pulses last exactly one cycle; out_*_data holds until the next done.

Optional Feature:
- Macro MEM_CTRL_IO_STALL_EN.
- With it defined:
  - A STORE stage whose address >= IO_BASE holds (no byte issued, k frozen, out_mem_wr = 0) while in_io_buffer_full = 1.
  - Loads from the IO region issue only when the controller is not stalled.
- Without it: in_io_buffer_full is ignored.

Decomposition:
- Shared definitions header: state encodings, size codes (SIZE_B/H/W), DATA_TYPE, ZERO_WORD, TRUE/FALSE, IO_BASE default.
- No sub-module; the pending-slot latch is small enough to stay inline.

Test Plan:
- Fetch 0x0, RAM bytes 13 05 00 00: out_fetcher_inst = 32'h00000513; out_fetcher_flag pulses 5 cycles after the request; exactly 4 reads at addresses 0..3.
- LSB load half at 0x101, RAM[0x101..0x102] = 34 12: out_lsb_data = 32'h00001234 after 3 cycles.
- Store word 0xDEADBEEF at 0x200: writes EF, BE, AD, DE to 0x200..0x203 with out_mem_wr = 1 on 4 cycles; out_lsb_flag on the 5th cycle.
- Simultaneous fetch and load pulses: the load runs first, the fetch starts the cycle after load done, and both data values are correct.
- in_rob_xbp at stage 2 of a fetch: no out_fetcher_flag; controller idle next cycle. xbp during a store: the store completes and pulses done.
- With MEM_CTRL_IO_STALL_EN: store byte to 0x30004 while in_io_buffer_full = 1 for 3 cycles: no write for those cycles, then a single write and done pulse.
